led_7_seg_mux: RTL and testbench

LED_7_SEG_MUX -- requirements
Module: led_7_seg_mux

---
 rtl/led_7_seg_mux.sv | 112 +++++++++++
 tb/tb_led_7_seg_mux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_7_seg_mux.sv
// Character buffer driven by an ASCII stream, shown on a time-multiplexed
// 7-segment display with registered, ghost-free segment and anode outputs.
module led_7_seg_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_valid,
    input  logic                              clear,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             an,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   char_count
);

    localparam int CCW = $clog2(NUM_DIGITS + 1);
    localparam int CW  = $clog2(REFRESH_DIV);
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CCW-1:0] CNT_FULL = CCW'(NUM_DIGITS);
    localparam logic [CW-1:0]  TICK_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]     SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_FIRST =
        AN_ACTIVE_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);

    logic [7:0]            buf_q [NUM_DIGITS];
    logic [CW-1:0]         tick_cnt;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         idx_next;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic                  is_print;
    logic                  is_bs;
    logic                  is_eol;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [7:0] c);
        logic [6:0] d;
        case (c)
            8'h30: d = 7'b1000000;
            8'h31: d = 7'b1111001;
            8'h32: d = 7'b0100100;
            8'h33: d = 7'b0110000;
            8'h34: d = 7'b0011001;
            8'h35: d = 7'b0010010;
            8'h36: d = 7'b0000010;
            8'h37: d = 7'b1111000;
            8'h38: d = 7'b0000000;
            8'h39: d = 7'b0010000;
            8'h41, 8'h61: d = 7'b0001000;
            8'h42, 8'h62: d = 7'b0000011;
            8'h43, 8'h63: d = 7'b1000110;
            8'h44, 8'h64: d = 7'b0100001;
            8'h45, 8'h65: d = 7'b0000110;
            8'h46, 8'h66: d = 7'b0001110;
            8'h2D: d = 7'b0111111;
            8'h5F: d = 7'b1110111;
            default: d = 7'b1111111;
        endcase
        return d;
    endfunction

    assign is_print = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
    assign is_bs    = (rx_data == 8'h08);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= 8'h20;
            char_count <= '0;
        end else if (clear || (rx_valid && is_eol)) begin
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= 8'h20;
            char_count <= '0;
        end else if (rx_valid && is_print) begin
            for (int i = 1; i < NUM_DIGITS; i++) buf_q[i] <= buf_q[i-1];
            buf_q[0] <= rx_data;
            if (char_count != CNT_FULL) char_count <= char_count + 1'b1;
        end else if (rx_valid && is_bs) begin
            for (int i = 0; i < NUM_DIGITS - 1; i++) buf_q[i] <= buf_q[i+1];
            buf_q[NUM_DIGITS-1] <= 8'h20;
            if (char_count != '0) char_count <= char_count - 1'b1;
        end
    end

    // seg/an are both derived from idx_next so they always switch together
    always_comb begin
        idx_next = idx;
        if (tick_cnt == TICK_LAST) idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        seg_next = SEG_ACTIVE_LOW ? decode(buf_q[idx_next]) : ~decode(buf_q[idx_next]);
        an_next  = NUM_DIGITS'(1) << idx_next;
        if (AN_ACTIVE_LOW) an_next = ~an_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_BLANK;
            an       <= AN_FIRST;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            idx      <= idx_next;
            seg      <= seg_next;
            an       <= an_next;
        end
    end

endmodule

// File: tb/tb_led_7_seg_mux.sv
// Directed bench for led_7_seg_mux: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_led_7_seg_mux;

    typedef struct {
        string      name;
        logic [6:0] seg;
        logic [3:0] an;
        logic [2:0] cnt;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       clear = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] char_count;

    int   edges = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t m_e;

    localparam logic [6:0] BLK = 7'b1111111;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    led_7_seg_mux #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(4),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .clear(clear),
        .seg(seg),
        .an(an),
        .char_count(char_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else edges <= edges + 1;
    end

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= edges) begin
            m_e = q.pop_front();
            n_cmp++;
            if (seg !== m_e.seg || an !== m_e.an || char_count !== m_e.cnt) begin
                n_bad++;
                $display("FAIL %s: got seg=%b an=%b cnt=%0d, want seg=%b an=%b cnt=%0d",
                         m_e.name, seg, an, char_count, m_e.seg, m_e.an, m_e.cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [6:0] s,
                              input logic [3:0] a, input logic [2:0] c);
        q.push_back('{nm, s, a, c, edges});
    endtask

    task automatic check_digit(input string nm, input int d,
                               input logic [6:0] s, input logic [2:0] c);
        int k = 0;
        tick();
        while (((edges / 4) % 4) != d && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout waiting for digit %0d slot", nm, d);
        end else begin
            expect_now(nm, s, an_tab[d], c);
        end
    endtask

    task automatic wait_slot_start(input int d);
        int k = 0;
        while (!(((edges / 4) % 4) == d && (edges % 4) == 0) && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        rx_data  = c;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_clear(input logic v, input logic [7:0] c);
        clear    = 1'b1;
        rx_valid = v;
        rx_data  = c;
        tick();
        clear    = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #1;
        expect_now("reset_state", BLK, 4'b1110, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            expect_now("idle_scan", BLK, an_tab[i / 4], 3'd0);
            tick();
        end

        send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
        check_digit("shift_d0_5", 0, 7'b0010010, 3'd4);
        check_digit("shift_d1_4", 1, 7'b0011001, 3'd4);
        check_digit("shift_d2_3", 2, 7'b0110000, 3'd4);
        check_digit("shift_d3_2", 3, 7'b0100100, 3'd4);

        do_clear(1'b0, 8'h00);
        check_digit("clear_d3", 3, BLK, 3'd0);
        send(8'h61); send(8'h46); send(8'h08);
        check_digit("bs_d0_a", 0, 7'b0001000, 3'd1);
        check_digit("bs_d1_blank", 1, BLK, 3'd1);
        send(8'h08); send(8'h08);
        check_digit("bs_sat_d0", 0, BLK, 3'd0);

        send(8'h38);
        check_digit("load_8", 0, 7'b0000000, 3'd1);
        do_clear(1'b1, 8'h37);
        check_digit("clr_rx_d0", 0, BLK, 3'd0);
        check_digit("clr_rx_d1", 1, BLK, 3'd0);

        send(8'h45);
        check_digit("e_d0", 0, 7'b0000110, 3'd1);
        send(8'h0D);
        check_digit("cr_d0", 0, BLK, 3'd0);
        send(8'h47);
        check_digit("g_d0", 0, BLK, 3'd1);
        send(8'h2D); send(8'h0A);
        check_digit("lf_d1", 1, BLK, 3'd0);
        send(8'h5F); send(8'h01);
        check_digit("other_d0", 0, 7'b1110111, 3'd1);

        wait_slot_start(0);
        send(8'h30);
        check_digit("latency_d0", 0, 7'b1000000, 3'd2);
        check_digit("latency_d1", 1, 7'b1110111, 3'd2);

        send(8'h39);
        check_digit("pre_rst_9", 0, 7'b0010000, 3'd3);
        k = 0;
        while (!(((edges / 4) % 4) == 2 && (edges % 4) == 1) && k < 40) begin
            tick();
            k++;
        end
        rx_data  = 8'h39;
        rx_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        expect_now("async_rst", BLK, 4'b1110, 3'd0);
        tick();
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        check_digit("post_rst_d0", 0, BLK, 3'd0);
        check_digit("post_rst_d1", 1, BLK, 3'd0);

        k = 0;
        while (q.size() > 0 && k < 20) begin
            tick();
            k++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d checks left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
